alu_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle CPU ALU.
- Single-cycle logic/arith/shift ops complete in one clocked stage.
- Iterative unsigned multiply and divide/remainder take WIDTH cycles.
- Valid/ready handshake on both sides, so the EX stage can stall on busy; result and zero flag are registered.

---
 rtl/alu_mc_pkg.sv | 29 ++
 rtl/alu_mc_iter.sv | 86 ++++++++
 rtl/alu_mc.sv | 125 ++++++++++++
 tb/tb_alu_mc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, handshake FSM states
// and the default LUI shift amount.
package alu_mc_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_LUI  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;
    localparam logic [3:0] OP_REMU = 4'b1010;
    localparam logic [3:0] OP_SRL  = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // LUI places B in the upper half of the word by default.
    function automatic int lui_shift_default(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide/remainder.
// One step per clock; WIDTH steps after start, o_done rises once the
// counter is exhausted. Divider steps exist only with ALU_MC_DIV_EN.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_rem,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_value
);

    // r_hi: product accumulator / partial remainder
    // r_lo: multiplier (shifting right) / dividend-then-quotient (shifting left)
    // r_b : multiplicand (shifting left) / divisor (constant)
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;
    logic             r_div;
    logic             r_rem;

    logic [WIDTH-1:0] w_sum;
    assign w_sum = r_hi + r_b;

`ifdef ALU_MC_DIV_EN
    // Remainder can never exceed the divisor, so one extra bit is enough
    // to tell whether the trial subtraction borrowed.
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_b};
`endif

    // Load operands on start, then run one mul or div step per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_rem <= 1'b0;
        end else if (i_start) begin
            r_cnt <= CNT_W'(WIDTH);
            r_hi  <= '0;
            r_lo  <= i_div ? i_a : i_b;
            r_b   <= i_div ? i_b : i_a;
            r_div <= i_div;
            r_rem <= i_rem;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
`ifdef ALU_MC_DIV_EN
            if (r_div) begin
                if (!w_diff[WIDTH]) begin
                    r_hi <= w_diff[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shift[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (r_lo[0]) r_hi <= w_sum;
                r_lo <= r_lo >> 1;
                r_b  <= r_b << 1;
            end
`else
            if (r_lo[0]) r_hi <= w_sum;
            r_lo <= r_lo >> 1;
            r_b  <= r_b << 1;
`endif
        end
    end

    assign o_done  = (r_cnt == '0);
    assign o_value = r_div ? (r_rem ? r_hi : r_lo) : r_hi;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake. Single-cycle ops register
// their result at the accept edge; MUL (and DIVU/REMU when ALU_MC_DIV_EN
// is defined) run through alu_mc_iter for WIDTH+1 edges.
//
//   state | meaning
//   IDLE  | ready for a request, in_ready=1
//   BUSY  | iterative op running, busy=1
//   DONE  | result presented, held until out_ready
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int LUI_SHIFT = lui_shift_default(WIDTH),
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic [WIDTH-1:0] w_alu;
    logic [SH_W-1:0]  w_shamt;
    logic             w_is_div;
    logic             w_is_iter;
    logic             w_accept;
    logic             w_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_value;

    assign w_shamt = b[SH_W-1:0];

`ifdef ALU_MC_DIV_EN
    assign w_is_div = (op == OP_DIVU) || (op == OP_REMU);
`else
    assign w_is_div = 1'b0;
`endif
    assign w_is_iter = (op == OP_MUL) || w_is_div;
    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_start   = w_accept && w_is_iter;

    // Single-cycle result mux; anything not listed falls back to ADD.
    always_comb begin
        w_alu = a + b;
        case (op)
            OP_SUB:  w_alu = a - b;
            OP_AND:  w_alu = a & b;
            OP_OR:   w_alu = a | b;
            OP_XOR:  w_alu = a ^ b;
            OP_LUI:  w_alu = b << LUI_SHIFT;
            OP_SLT:  w_alu = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            OP_SLL:  w_alu = a << w_shamt;
            OP_SRL:  w_alu = a >> w_shamt;
            default: w_alu = a + b;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_div   (w_is_div),
        .i_rem   (op == OP_REMU),
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_iter_done),
        .o_value (w_iter_value)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic for the handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)    w_state_nxt = w_is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_iter_done) w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready)   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Result/zero capture: at accept for single-cycle ops, at finish for iterative.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_accept && !w_is_iter) begin
            r_result <= w_alu;
            r_zero   <= ~|w_alu;
        end else if ((r_state == ST_BUSY) && w_iter_done) begin
            r_result <= w_iter_value;
            r_zero   <= ~|w_iter_value;
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_BUSY);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32). Stimulus pushes expected results;
// a monitor pops and compares on each output transfer.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every out_valid && out_ready transfer is checked against the queue.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", result, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk(result == e, "result", result, e);
                    chk(zero == ~|e, "zero", {31'd0, zero}, {31'd0, ~|e});
                end
            end
        end
    end

    // Wait for in_ready, present a request for one accept edge.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] e, input bit push);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk(in_ready, "issue_timeout", {31'd0, in_ready}, 32'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Issue and measure edges from accept until out_valid.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] e, input int exp_lat, input string name);
        int lat = 0;
        bit iter_ok = 1'b1;
        issue(o, x, y, e, 1'b1);
        while (!out_valid && lat < 100) begin
            if (!busy || in_ready) iter_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk(lat == exp_lat, {name, "_latency"}, lat, exp_lat);
        if (exp_lat > 0) chk(iter_ok, {name, "_busy_noready"}, {31'd0, iter_ok}, 32'd1);
    endtask

    initial begin
        bit hold_ok;
        #100_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hold_ok;
        int lat_iter;
        lat_iter = W + 1;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk(!out_valid, "rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk(result == 0, "rst_result", result, 32'd0);
        chk(zero, "rst_zero", {31'd0, zero}, 32'd1);
        chk(!busy, "rst_busy", {31'd0, busy}, 32'd0);
        chk(in_ready, "rst_in_ready", {31'd0, in_ready}, 32'd1);

        run_op(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, "add_ovf");
        run_op(4'b0100, 32'd5, 32'd5, 32'd0, 0, "sub_zero");
        run_op(4'b0110, 32'h0000_DEAD, 32'h0000_1234, 32'h1234_0000, 0, "lui");
        run_op(4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, "slt_neg");
        run_op(4'b0011, 32'd1, 32'hFFFF_FFFF, 32'd0, 0, "slt_pos");
        run_op(4'b1011, 32'h8000_0000, 32'd31, 32'd1, 0, "srl");
        run_op(4'b0111, 32'd3, 32'h21, 32'd6, 0, "sll_wrap");
        run_op(4'b0001, 32'hF0F0, 32'hFF00, 32'hF000, 0, "and");
        run_op(4'b0101, 32'hF0F0, 32'hFF00, 32'hFFF0, 0, "or");
        run_op(4'b0010, 32'hF0F0, 32'hFF00, 32'h0FF0, 0, "xor");
        run_op(4'b1111, 32'd2, 32'd3, 32'd5, 0, "undef_f");
        run_op(4'b1100, 32'd10, 32'd20, 32'd30, 0, "undef_c");

        run_op(4'b1000, 32'hFFFF, 32'hFFFF, 32'hFFFE_0001, lat_iter, "mul_ffff");
        run_op(4'b1000, 32'h1234_5678, 32'd0, 32'd0, lat_iter, "mul_zero");
        run_op(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, lat_iter, "mul_max");
        run_op(4'b1000, 32'd12345, 32'd6789, 32'd83810205, lat_iter, "mul_mid");

`ifdef ALU_MC_DIV_EN
        run_op(4'b1001, 32'd100, 32'd7, 32'd14, lat_iter, "divu");
        run_op(4'b1010, 32'd100, 32'd7, 32'd2, lat_iter, "remu");
        run_op(4'b1001, 32'd5, 32'd0, 32'hFFFF_FFFF, lat_iter, "divu_by0");
        run_op(4'b1010, 32'd9, 32'd0, 32'd9, lat_iter, "remu_by0");
        run_op(4'b1001, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, lat_iter, "divu_big");
`else
        run_op(4'b1001, 32'd100, 32'd7, 32'd107, 0, "divu_as_add");
        run_op(4'b1010, 32'd100, 32'd7, 32'd107, 0, "remu_as_add");
        run_op(4'b1001, 32'd5, 32'd0, 32'd5, 0, "divu0_as_add");
`endif

        // Backpressure: result held while out_ready is low and a new request waits.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        issue(4'b0000, 32'd3, 32'd4, 32'd7, 1'b1);
        op = 4'b0010;
        a = 32'd1;
        b = 32'd1;
        in_valid = 1'b1;
        hold_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || result != 32'd7 || zero || in_ready) hold_ok = 1'b0;
        end
        chk(hold_ok, "backpressure_hold", result, 32'd7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk(in_ready && !out_valid, "drain_to_idle", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset during MUL at BUSY cycle 10.
        issue(4'b1000, 32'h1234, 32'h5678, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        chk(busy, "mul_busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk(in_ready && !out_valid && !busy, "rst_abort_state",
            {29'd0, in_ready, out_valid, busy}, 32'd4);
        chk(result == 0, "rst_abort_result", result, 32'd0);
        chk(zero, "rst_abort_zero", {31'd0, zero}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        chk(!out_valid, "rst_abort_no_valid", {31'd0, out_valid}, 32'd0);
        run_op(4'b0000, 32'd1, 32'd1, 32'd2, 0, "add_after_rst");

        repeat (4) @(posedge clk);
        #1;
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
